// File: rtl/lfsr_galois_ctrl.sv
// lfsr_galois_ctrl: job sequencer for one Galois LFSR instance.
// Loads a seed, steps the LFSR per accepted word, reports the first return-to-seed.
module lfsr_galois_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  input  logic               CMD_VALID_I,
  output logic               CMD_READY_O,
  input  logic [MAX_LEN-1:0] CMD_SEED_I,
  input  logic [MAX_LEN-1:0] CMD_POLY_I,
  input  logic [CNT_W-1:0]   CMD_LEN_I,
  input  logic               ABORT_I,
  output logic               OUT_VALID_O,
  input  logic               OUT_READY_I,
  output logic [MAX_LEN-1:0] OUT_DATA_O,
  output logic               OUT_LAST_O,
  output logic               LFSR_LOAD_O,
  output logic               LFSR_EN_O,
  output logic [MAX_LEN-1:0] LFSR_SEED_O,
  output logic [MAX_LEN-1:0] LFSR_POLY_O,
  input  logic [MAX_LEN-1:0] LFSR_DATA_I,
  output logic               BUSY_O,
  output logic               ERR_O,
  output logic               WRAP_O,
  output logic [CNT_W-1:0]   PERIOD_O
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [MAX_LEN-1:0] seed_q, seed_d;
  logic [MAX_LEN-1:0] poly_q, poly_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   per_q, per_d;

  logic idle, run, acc, bad, xfer, last, wrap;

  // Handshake and status decode; ready is held low while reset is asserted.
  always_comb begin
    idle        = (state_q == S_IDLE);
    run         = (state_q == S_RUN);
    CMD_READY_O = RST_N_I & idle;
    acc         = CMD_VALID_I & CMD_READY_O;
    bad         = (CMD_SEED_I == '0) || (CMD_LEN_I == '0);
    OUT_VALID_O = run & ~ABORT_I;
    xfer        = OUT_VALID_O & OUT_READY_I;
    last        = (idx_q == len_q - 1'b1);
    wrap        = xfer && (idx_q != '0) &&
                  (LFSR_DATA_I == seed_q) && (per_q == '0);
    OUT_LAST_O  = OUT_VALID_O & last;
    OUT_DATA_O  = run ? LFSR_DATA_I : '0;
    LFSR_LOAD_O = (state_q == S_LOAD);
    LFSR_EN_O   = xfer;
    LFSR_SEED_O = seed_q;
    LFSR_POLY_O = poly_q;
    BUSY_O      = ~idle;
    ERR_O       = acc & bad;
    WRAP_O      = wrap;
    PERIOD_O    = per_q;
  end

  // Next-state and job register update.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    poly_d  = poly_q;
    len_d   = len_q;
    idx_d   = idx_q;
    per_d   = per_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc && !bad) begin
          seed_d  = CMD_SEED_I;
          poly_d  = CMD_POLY_I;
          len_d   = CMD_LEN_I;
          idx_d   = '0;
          per_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = ABORT_I ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (ABORT_I) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (wrap) per_d = idx_q;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and job registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      poly_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      per_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      poly_q  <= poly_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
    end
  end

endmodule
